// File: rtl/wb_mux_lock_pkg.sv
// Shared types for the locking Wishbone multiplexer.
package wb_mux_lock_pkg;

  // Controller states: waiting for a cycle, forwarding to a locked slave,
  // or emitting a single-cycle error termination.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_mux_lock_addr_decode.sv
// Prefix/mask address decoder with lowest-index priority.
// Reusable by arbiters and interconnects that need a port index.
module wb_addr_decode #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [ADDR_WIDTH-1:0]       adr,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [PORTS*ADDR_WIDTH-1:0] msk,
  output logic                        match_valid,
  output logic [IDX_WIDTH-1:0]        match_idx
);

  logic [PORTS-1:0] match;

  // A port matches when every unmasked address bit equals its prefix.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_match
    assign match[gi] = ~|((adr ^ addr[gi*ADDR_WIDTH +: ADDR_WIDTH]) &
                          msk[gi*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  // Priority encoder: scanning downwards leaves the lowest matching index.
  always_comb begin
    match_valid = 1'b0;
    match_idx   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        match_valid = 1'b1;
        match_idx   = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/wb_mux_lock.sv
// One-master, PORTS-slave Wishbone classic mux. The slave is decoded once
// per CYC and locked until CYC drops; decode misses and hung slaves end
// with a single-cycle ERR so the master never stalls.
module wb_mux_lock
  import wb_mux_lock_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int PORTS        = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]         wbm_dat_i,
  input  logic                          wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]       wbm_sel_i,
  input  logic                          wbm_stb_i,
  input  logic                          wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]         wbm_dat_o,
  output logic                          wbm_ack_o,
  output logic                          wbm_err_o,
  output logic                          wbm_rty_o,
  output logic [PORTS*ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [PORTS*DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [PORTS*SELECT_WIDTH-1:0] wbs_sel_o,
  output logic [PORTS-1:0]              wbs_we_o,
  output logic [PORTS-1:0]              wbs_stb_o,
  output logic [PORTS-1:0]              wbs_cyc_o,
  input  logic [PORTS*DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [PORTS-1:0]              wbs_ack_i,
  input  logic [PORTS-1:0]              wbs_err_i,
  input  logic [PORTS-1:0]              wbs_rty_i,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbs_addr,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbs_addr_msk
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [CW-1:0]   cnt_reg;

  logic            match_valid;
  logic [GW-1:0]   match_idx;

  logic            active;
  logic            g_ack;
  logic            g_err;
  logic            g_rty;
  logic            g_term;
  logic [DATA_WIDTH-1:0] g_dat;

  wb_addr_decode #(
    .PORTS      (PORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (GW)
  ) u_decode (
    .adr         (wbm_adr_i),
    .addr        (wbs_addr),
    .msk         (wbs_addr_msk),
    .match_valid (match_valid),
    .match_idx   (match_idx)
  );

  assign active = (state_reg == ST_ACTIVE);

  // Select the response of the locked slave; other slaves are never looked at.
  always_comb begin
    g_ack  = wbs_ack_i[grant_reg];
    g_err  = wbs_err_i[grant_reg];
    g_rty  = wbs_rty_i[grant_reg];
    g_dat  = wbs_dat_i[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
    g_term = g_ack | g_err | g_rty;
  end

  // Master-side response: pass-through while locked, forced ERR in ABORT.
  always_comb begin
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_rty_o = 1'b0;
    wbm_err_o = (state_reg == ST_ABORT);
    if (active) begin
      wbm_dat_o = g_dat;
      wbm_ack_o = g_ack;
      wbm_rty_o = g_rty;
      wbm_err_o = g_err;
    end
  end

  // Request fields are broadcast; controls go only to the granted port and
  // follow the master combinationally so they drop with CYC.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    logic sel;
    assign sel = active && (grant_reg == GW'(gi));
    assign wbs_cyc_o[gi] = sel & wbm_cyc_i;
    assign wbs_stb_o[gi] = sel & wbm_stb_i;
    assign wbs_we_o[gi]  = sel & wbm_we_i;
    assign wbs_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]     = wbm_adr_i;
    assign wbs_dat_o[gi*DATA_WIDTH +: DATA_WIDTH]     = wbm_dat_i;
    assign wbs_sel_o[gi*SELECT_WIDTH +: SELECT_WIDTH] = wbm_sel_i;
  end

  // Control FSM: decode on cycle start, lock the grant, run the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (wbm_cyc_i && wbm_stb_i) begin
            if (match_valid) begin
              grant_reg <= match_idx;
              state_reg <= ST_ACTIVE;
            end else begin
              state_reg <= ST_ABORT;
            end
          end
        end
        ST_ACTIVE: begin
          if (!wbm_cyc_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if ((TIMEOUT > 0) && wbm_stb_i && !g_term) begin
            // A termination in the final cycle wins over the timeout.
            if (cnt_reg == CNT_LAST) begin
              state_reg <= ST_ABORT;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
        ST_ABORT: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mux_lock.sv
// Directed bench for wb_mux_lock: a table of single transfers plus
// hand-written sequences for timeout, locking, abort and reset corners.
module tb_wb_mux_lock;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int NP = 4;
  localparam int TO = 4;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   wbm_adr_i;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_we_i;
  logic [SW-1:0]   wbm_sel_i;
  logic            wbm_stb_i;
  logic            wbm_cyc_i;
  logic [DW-1:0]   wbm_dat_o;
  logic            wbm_ack_o;
  logic            wbm_err_o;
  logic            wbm_rty_o;
  logic [NP*AW-1:0] wbs_adr_o;
  logic [NP*DW-1:0] wbs_dat_o;
  logic [NP*SW-1:0] wbs_sel_o;
  logic [NP-1:0]   wbs_we_o;
  logic [NP-1:0]   wbs_stb_o;
  logic [NP-1:0]   wbs_cyc_o;
  logic [NP*DW-1:0] wbs_dat_i;
  logic [NP-1:0]   wbs_ack_i;
  logic [NP-1:0]   wbs_err_i;
  logic [NP-1:0]   wbs_rty_i;
  logic [NP*AW-1:0] wbs_addr;
  logic [NP*AW-1:0] wbs_addr_msk;

  int n_checks = 0;
  int n_fail   = 0;

  wb_mux_lock #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .SELECT_WIDTH (SW),
    .PORTS        (NP),
    .TIMEOUT      (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wbm_adr_i    (wbm_adr_i),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_we_i     (wbm_we_i),
    .wbm_sel_i    (wbm_sel_i),
    .wbm_stb_i    (wbm_stb_i),
    .wbm_cyc_i    (wbm_cyc_i),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_ack_o    (wbm_ack_o),
    .wbm_err_o    (wbm_err_o),
    .wbm_rty_o    (wbm_rty_o),
    .wbs_adr_o    (wbs_adr_o),
    .wbs_dat_o    (wbs_dat_o),
    .wbs_sel_o    (wbs_sel_o),
    .wbs_we_o     (wbs_we_o),
    .wbs_stb_o    (wbs_stb_o),
    .wbs_cyc_o    (wbs_cyc_o),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_ack_i    (wbs_ack_i),
    .wbs_err_i    (wbs_err_i),
    .wbs_rty_i    (wbs_rty_i),
    .wbs_addr     (wbs_addr),
    .wbs_addr_msk (wbs_addr_msk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] adr);
    wbm_adr_i = adr;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbs_ack_i = '0;
  endtask

  initial begin
    // Port map: 0 -> 0x0, 1 -> 0x1, 2 -> 0x0/0x2 (overlaps port 0), 3 -> 0x3.
    wbs_addr     = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    wbs_addr_msk = {32'hF000_0000, 32'hD000_0000, 32'hF000_0000, 32'hF000_0000};
    wbs_dat_i    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    wbs_err_i    = '0;
    wbs_rty_i    = '0;
    wbm_dat_i    = 32'h1234_5678;
    wbm_sel_i    = 4'hF;
    wbm_we_i     = 1'b0;
    wbm_adr_i    = '0;
    wbm_cyc_i    = 1'b0;
    wbm_stb_i    = 1'b0;

    vecs[0] = '{32'h1000_0004, 4'b0010, 1'b0, 32'hCAFE_0001};
    vecs[1] = '{32'h7000_0000, 4'b0000, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h0000_0010, 4'b0001, 1'b0, 32'hCAFE_0000};
    vecs[3] = '{32'h2000_0000, 4'b0100, 1'b0, 32'hCAFE_0002};
    vecs[4] = '{32'h3000_0008, 4'b1000, 1'b0, 32'hCAFE_0003};

    // Reset, with every slave acking to show IDLE ignores responses.
    rst       = 1'b1;
    wbs_ack_i = '1;
    tick(); tick(); tick();
    check("reset_cyc", 64'(wbs_cyc_o), 64'h0);
    check("reset_stb", 64'(wbs_stb_o), 64'h0);
    check("reset_ack", 64'(wbm_ack_o), 64'h0);
    check("reset_err", 64'(wbm_err_o), 64'h0);
    check("reset_dat", 64'(wbm_dat_o), 64'h0);
    rst       = 1'b0;
    wbs_ack_i = '0;
    tick();

    // Table of single transfers.
    for (int v = 0; v < 5; v++) begin
      request(vecs[v].adr);
      #1;
      check($sformatf("v%0d_c0_cyc", v), 64'(wbs_cyc_o), 64'h0);
      tick();
      check($sformatf("v%0d_c1_stb", v), 64'(wbs_stb_o), 64'(vecs[v].exp_stb));
      check($sformatf("v%0d_c1_cyc", v), 64'(wbs_cyc_o), 64'(vecs[v].exp_stb));
      check($sformatf("v%0d_c1_err", v), 64'(wbm_err_o), 64'(vecs[v].exp_err));
      if (!vecs[v].exp_err) begin
        wbs_ack_i = vecs[v].exp_stb;
        #1;
        check($sformatf("v%0d_ack", v), 64'(wbm_ack_o), 64'h1);
        check($sformatf("v%0d_dat", v), 64'(wbm_dat_o), 64'(vecs[v].exp_dat));
        tick();
        release_bus();
        #1;
        check($sformatf("v%0d_drop_cyc", v), 64'(wbs_cyc_o), 64'h0);
      end else begin
        release_bus();
      end
      tick();
      check($sformatf("v%0d_idle_err", v), 64'(wbm_err_o), 64'h0);
      $display("vec %0d adr=%08h stb=%b err=%0d dat=%08h", v, vecs[v].adr,
               vecs[v].exp_stb, vecs[v].exp_err, vecs[v].exp_dat);
    end

    // Timeout: slave never answers.
    request(32'h1000_0000);
    for (int c = 1; c <= TO; c++) begin
      tick();
      check($sformatf("to_c%0d_stb", c), 64'(wbs_stb_o), 64'h2);
      check($sformatf("to_c%0d_err", c), 64'(wbm_err_o), 64'h0);
    end
    tick();
    check("to_err_pulse", 64'(wbm_err_o), 64'h1);
    check("to_err_stb",   64'(wbs_stb_o), 64'h0);
    check("to_err_cyc",   64'(wbs_cyc_o), 64'h0);
    release_bus();
    tick();
    check("to_after_err", 64'(wbm_err_o), 64'h0);
    $display("seq timeout: err after %0d stb cycles", TO);

    // Ack in the last allowed cycle wins over the watchdog.
    request(32'h1000_0000);
    tick(); tick(); tick(); tick();
    wbs_ack_i = 4'b0010;
    #1;
    check("lastack_ack", 64'(wbm_ack_o), 64'h1);
    check("lastack_err", 64'(wbm_err_o), 64'h0);
    tick();
    wbs_ack_i = '0;
    #1;
    check("lastack_next_err", 64'(wbm_err_o), 64'h0);
    check("lastack_next_stb", 64'(wbs_stb_o), 64'h2);
    release_bus();
    tick();
    $display("seq ack at timeout edge: ack delivered");

    // Locked grant: two transfers in one CYC, second addresses port 3.
    request(32'h0000_0010);
    tick();
    wbs_ack_i = 4'b0001;
    #1;
    check("lock_t1_ack", 64'(wbm_ack_o), 64'h1);
    check("lock_t1_dat", 64'(wbm_dat_o), 64'hCAFE_0000);
    tick();
    wbm_adr_i = 32'h3000_0000;
    wbs_ack_i = 4'b1000;
    #1;
    check("lock_t2_stb",      64'(wbs_stb_o), 64'h1);
    check("lock_spurious_ack", 64'(wbm_ack_o), 64'h0);
    tick();
    wbs_ack_i = 4'b0001;
    #1;
    check("lock_t2_ack", 64'(wbm_ack_o), 64'h1);
    check("lock_t2_dat", 64'(wbm_dat_o), 64'hCAFE_0000);
    release_bus();
    tick();
    $display("seq lock: both transfers on port 0");

    // Decode miss where the master abandons CYC during the error cycle.
    request(32'h7000_0000);
    tick();
    release_bus();
    #1;
    check("abort_drop_err", 64'(wbm_err_o), 64'h1);
    check("abort_drop_cyc", 64'(wbs_cyc_o), 64'h0);
    tick();
    check("abort_drop_idle", 64'(wbm_err_o), 64'h0);
    $display("seq abort with cyc dropped: single err pulse");

    // Reset while port 2 is mid-transfer, then a fresh decode.
    request(32'h2000_0000);
    tick();
    check("rst_pre_stb", 64'(wbs_stb_o), 64'h4);
    wbs_ack_i = 4'b0100;
    rst       = 1'b1;
    tick();
    check("rst_cyc", 64'(wbs_cyc_o), 64'h0);
    check("rst_ack", 64'(wbm_ack_o), 64'h0);
    rst       = 1'b0;
    wbs_ack_i = '0;
    wbm_adr_i = 32'h1000_0004;
    tick();
    check("rst_new_stb", 64'(wbs_stb_o), 64'h2);
    wbs_ack_i = 4'b0010;
    #1;
    check("rst_new_dat", 64'(wbm_dat_o), 64'hCAFE_0001);
    tick();
    release_bus();
    tick();
    $display("seq reset mid-transfer: new request to port 1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
